// File: rtl/br_perf_pkg.sv
// Shared types and constants for the branch-predictor performance monitor.
package br_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_CYC    = 3'd0,
        SEL_INSTR  = 3'd1,
        SEL_BR     = 3'd2,
        SEL_MISS   = 3'd3,
        SEL_STREAK = 3'd4
    } sel_e;

    localparam int OVF_CYC   = 0;
    localparam int OVF_INSTR = 1;
    localparam int OVF_BR    = 2;
    localparam int OVF_MISS  = 3;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    // Only full-width (non-compressed) encodings count, and the canonical NOP is a bubble.
    function automatic logic isCountedInstr(input logic [31:0] word, input logic [31:0] nopWord);
        return (word[1:0] == 2'b11) && (word != nopWord);
    endfunction

endpackage

// File: rtl/br_perf_sat_cnt.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag
// that is set when an increment is attempted at the maximum value.
module br_perf_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/br_perf_monitor.sv
// Branch-predictor performance monitor: windowed event counters with a 1-cycle readout port.
// Optional feature: define BR_PERF_STREAK_EN to add a max consecutive-miss streak on select 4.
module br_perf_monitor
    import br_perf_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    input  logic [31:0]      instr_i,
    input  logic             rd_req_i,
    input  logic [2:0]       rd_sel_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [1:0]       state_o,
    output logic [3:0]       ovf_o
);

    state_e state_q, state_d;
    logic   runEn;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // A pending stop blocks start, so start+stop in IDLE or HOLD leaves the state alone.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else if (stop_i) begin
            if (state_q == ST_RUN) state_d = ST_HOLD;
        end else if (start_i && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        runEn   = (state_q == ST_RUN);
        state_o = state_q;
    end

    logic evtEn_q, evtInstr_q, evtBr_q, evtMiss_q;
    logic evtEn_d, evtInstr_d, evtBr_d, evtMiss_d;

    // Events from a clear cycle are dropped so the counters come out of clear at zero.
    always_comb begin
        evtEn_d    = runEn && !clear_i;
        evtInstr_d = isCountedInstr(instr_i, NOP_WORD);
        evtBr_d    = br_instr_i;
        evtMiss_d  = br_miss_i && br_instr_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evtEn_q    <= 1'b0;
            evtInstr_q <= 1'b0;
            evtBr_q    <= 1'b0;
            evtMiss_q  <= 1'b0;
        end else begin
            evtEn_q    <= evtEn_d;
            evtInstr_q <= evtInstr_d;
            evtBr_q    <= evtBr_d;
            evtMiss_q  <= evtMiss_d;
        end
    end

    logic [CNT_W-1:0] cycCnt, instrCnt, brCnt, missCnt;
    logic [3:0]       ovfVec;

    br_perf_sat_cnt #(.W(CNT_W)) u_cycCnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(evtEn_q),
        .cnt_o(cycCnt), .ovf_o(ovfVec[OVF_CYC])
    );
    br_perf_sat_cnt #(.W(CNT_W)) u_instrCnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(evtEn_q && evtInstr_q),
        .cnt_o(instrCnt), .ovf_o(ovfVec[OVF_INSTR])
    );
    br_perf_sat_cnt #(.W(CNT_W)) u_brCnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(evtEn_q && evtBr_q),
        .cnt_o(brCnt), .ovf_o(ovfVec[OVF_BR])
    );
    br_perf_sat_cnt #(.W(CNT_W)) u_missCnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clear_i), .inc_i(evtEn_q && evtMiss_q),
        .cnt_o(missCnt), .ovf_o(ovfVec[OVF_MISS])
    );

    assign ovf_o = ovfVec;

`ifdef BR_PERF_STREAK_EN
    logic [CNT_W-1:0] streakCnt, streakMax_q, streakMax_d;
    logic             streakOvf;
    logic             streakRestart;

    // A correctly predicted branch ends the current run of misses.
    assign streakRestart = clear_i || (evtEn_q && evtBr_q && !evtMiss_q);

    br_perf_sat_cnt #(.W(CNT_W)) u_streakCnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(streakRestart), .inc_i(evtEn_q && evtMiss_q),
        .cnt_o(streakCnt), .ovf_o(streakOvf)
    );

    always_comb begin
        streakMax_d = streakMax_q;
        if (clear_i)                        streakMax_d = '0;
        else if (streakCnt > streakMax_q)   streakMax_d = streakCnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) streakMax_q <= '0;
        else       streakMax_q <= streakMax_d;
    end
`endif

    logic [CNT_W-1:0] selData;
    logic [CNT_W-1:0] rdData_q, rdData_d;
    logic             rdValid_q, rdValid_d;

    always_comb begin
        selData = '0;
        case (rd_sel_i)
            SEL_CYC:    selData = cycCnt;
            SEL_INSTR:  selData = instrCnt;
            SEL_BR:     selData = brCnt;
            SEL_MISS:   selData = missCnt;
`ifdef BR_PERF_STREAK_EN
            SEL_STREAK: selData = streakMax_q;
`endif
            default:    selData = '0;
        endcase
    end

    // Read data is sampled from the pre-update counter values, so a same-cycle clear is not seen.
    always_comb begin
        rdValid_d = rd_req_i;
        rdData_d  = rd_req_i ? selData : rdData_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            rdValid_q <= rdValid_d;
            rdData_q  <= rdData_d;
        end
    end

    assign rd_valid_o = rdValid_q;
    assign rd_data_o  = rdData_q;

endmodule

// File: tb/tb_br_perf_monitor.sv
// Scoreboard bench for br_perf_monitor (8-bit counters so saturation is reachable).
// Expected select-4 value depends on BR_PERF_STREAK_EN.
module tb_br_perf_monitor;

    localparam int W = 8;

    localparam logic [31:0] V1  = 32'h00A0_0093;
    localparam logic [31:0] V2  = 32'h00B5_0533;
    localparam logic [31:0] V3  = 32'hFFF0_0F13;
    localparam logic [31:0] V4  = 32'h0001_2083;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst, start, stop, clear, brInstr, brMiss, rdReq;
    logic [31:0]   instr;
    logic [2:0]    rdSel;
    logic          rdValid;
    logic [W-1:0]  rdData;
    logic [1:0]    stateOut;
    logic [3:0]    ovfOut;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;

    logic [W-1:0] expData[$];
    int           expDue[$];
    int           expSel[$];
    logic [W-1:0] popData;
    int           popDue;
    int           popSel;
    logic [W-1:0] expStreak;

    br_perf_monitor #(.CNT_W(W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_i(clear),
        .br_instr_i(brInstr), .br_miss_i(brMiss), .instr_i(instr),
        .rd_req_i(rdReq), .rd_sel_i(rdSel), .rd_valid_o(rdValid), .rd_data_o(rdData),
        .state_o(stateOut), .ovf_o(ovfOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Monitor: each valid beat must match the oldest outstanding read, one cycle after its request.
    always @(negedge clk) begin
        if (rdValid) begin
            checks++;
            if (expData.size() == 0) begin
                failures++;
                $display("[TB] FAIL read_unexpected: valid with data=%0d and no outstanding request", rdData);
            end else begin
                popData = expData.pop_front();
                popDue  = expDue.pop_front();
                popSel  = expSel.pop_front();
                if (rdData !== popData || cycleCount != popDue) begin
                    failures++;
                    $display("[TB] FAIL read_sel%0d: got data=%0d at cycle %0d, expected data=%0d at cycle %0d",
                             popSel, rdData, cycleCount, popData, popDue);
                end
            end
        end else if (expDue.size() > 0 && cycleCount > expDue[0]) begin
            checks++;
            failures++;
            popData = expData.pop_front();
            popDue  = expDue.pop_front();
            popSel  = expSel.pop_front();
            $display("[TB] FAIL read_timeout_sel%0d: no valid by cycle %0d, expected data=%0d at cycle %0d",
                     popSel, cycleCount, popData, popDue);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic cl,
                                 input logic br, input logic ms, input logic [31:0] ins);
        start   = st;
        stop    = sp;
        clear   = cl;
        brInstr = br;
        brMiss  = ms;
        instr   = ins;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doRead(input logic [2:0] sel, input logic [W-1:0] exp);
        rdReq = 1'b1;
        rdSel = sel;
        expData.push_back(exp);
        expDue.push_back(cycleCount + 1);
        expSel.push_back(int'(sel));
        tick();
    endtask

    task automatic endRead();
        rdReq = 1'b0;
        rdSel = 3'd0;
        tick();
        tick();
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        brV[10];
        logic        msV[10];
        logic [31:0] insV[10];
        logic        sbr[6];
        logic        sms[6];

        brV  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        msV  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        insV = '{V1, NOP, 32'h0000_4502, V2, 32'h0, NOP, V3, 32'h0000_0001, V4, 32'h0};
        sbr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        sms  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef BR_PERF_STREAK_EN
        expStreak = 8'd3;
`else
        expStreak = 8'd0;
`endif

        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        brInstr = 1'b0; brMiss = 1'b0; instr = 32'h0; rdReq = 1'b0; rdSel = 3'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("reset_state", int'(stateOut), 0);
        checkOutput("reset_ovf", int'(ovfOut), 0);
        checkOutput("reset_valid", int'(rdValid), 0);
        checkOutput("reset_data", int'(rdData), 0);
        for (int s = 0; s < 4; s++) doRead(3'(s), 8'd0);
        endRead();

        $display("[TB] ten-cycle window");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, (i == 9), 1'b0, brV[i], msV[i], insV[i]);
        idle(3);
        checkOutput("window_state_hold", int'(stateOut), 2);
        doRead(3'd0, 8'd10);
        doRead(3'd1, 8'd4);
        doRead(3'd2, 8'd3);
        doRead(3'd3, 8'd1);
        endRead();

        $display("[TB] miss without branch");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, (i == 4), 1'b0, 1'b0, 1'b1, 32'h0);
        idle(3);
        checkOutput("lonemiss_state_hold", int'(stateOut), 2);
        doRead(3'd3, 8'd1);
        doRead(3'd2, 8'd3);
        doRead(3'd0, 8'd15);
        endRead();

        $display("[TB] miss streak");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, (i == 5), 1'b0, sbr[i], sms[i], 32'h0);
        idle(3);
        doRead(3'd0, 8'd21);
        doRead(3'd1, 8'd4);
        doRead(3'd2, 8'd9);
        doRead(3'd3, 8'd6);
        doRead(3'd4, expStreak);
        doRead(3'd5, 8'd0);
        doRead(3'd7, 8'd0);
        endRead();

        $display("[TB] clear with simultaneous read");
        clear = 1'b1;
        doRead(3'd0, 8'd21);
        clear = 1'b0;
        doRead(3'd0, 8'd0);
        doRead(3'd2, 8'd0);
        doRead(3'd3, 8'd0);
        doRead(3'd4, 8'd0);
        endRead();
        checkOutput("clear_state_idle", int'(stateOut), 0);
        checkOutput("clear_ovf", int'(ovfOut), 0);

        $display("[TB] cycle counter saturation");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(299);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);
        checkOutput("sat_ovf", int'(ovfOut), 1);
        checkOutput("sat_state_hold", int'(stateOut), 2);
        doRead(3'd0, 8'd255);
        doRead(3'd1, 8'd0);
        endRead();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(2);
        checkOutput("sat_clear_ovf", int'(ovfOut), 0);
        checkOutput("sat_clear_state", int'(stateOut), 0);
        doRead(3'd0, 8'd0);
        endRead();

        $display("[TB] start+stop+clear in RUN");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V1);
        checkOutput("pre_allctl_state_run", int'(stateOut), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, V1);
        idle(2);
        checkOutput("allctl_state_idle", int'(stateOut), 0);
        doRead(3'd0, 8'd0);
        doRead(3'd2, 8'd0);
        endRead();

        $display("[TB] start+stop in IDLE");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);
        checkOutput("startstop_idle_state", int'(stateOut), 0);
        doRead(3'd0, 8'd0);
        endRead();

        $display("[TB] reset mid-window");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V2);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V2);
        rst = 1'b0;
        idle(2);
        checkOutput("rst_mid_state", int'(stateOut), 0);
        doRead(3'd0, 8'd0);
        doRead(3'd2, 8'd0);
        doRead(3'd1, 8'd0);
        endRead();

        idle(3);
        checkOutput("scoreboard_drained", expData.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
